pipe_share_arbiter: RTL and testbench

- Shares one stall-capable compute pipeline between two producer channels.
- Each channel uses the valid/stall/flush convention: the producer holds valid and data while stall is high and valid is high.
- Each channel is buffered in a small FIFO. A round-robin arbiter picks an entry into a registered output stage that drives the shared pipeline, tagged with its source.
- Per-channel flushes purge that channel's pending work and are forwarded to the pipeline as a mask.

---
 rtl/pipe_share_arbiter_if.sv | 21 ++
 rtl/pipe_share_arbiter.sv | 116 +++++++++++
 tb/tb_pipe_share_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_share_arbiter_if.sv
// pipe_share_arbiter_if: channel and shared-pipeline handshake bundle for pipe_share_arbiter
interface pipe_share_arbiter_if #(parameter int DATA_W = 32);
  logic              req_valid_0, req_valid_1;
  logic [DATA_W-1:0] req_data_0, req_data_1;
  logic              req_flush_0, req_flush_1;
  logic              req_stall_0, req_stall_1;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_tag;
  logic              pipe_stall;
  logic              pipe_flush;
  logic [1:0]        pipe_flush_mask;
  modport slave (
    input  req_valid_0, req_valid_1, req_data_0, req_data_1, req_flush_0, req_flush_1, pipe_stall,
    output req_stall_0, req_stall_1, pipe_valid, pipe_data, pipe_tag, pipe_flush, pipe_flush_mask
  );
  modport master (
    output req_valid_0, req_valid_1, req_data_0, req_data_1, req_flush_0, req_flush_1, pipe_stall,
    input  req_stall_0, req_stall_1, pipe_valid, pipe_data, pipe_tag, pipe_flush, pipe_flush_mask
  );
endinterface

// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter: two buffered valid/stall/flush channels round-robin shared into one registered pipeline stage.
// Optional ARB_PERF_CNT_EN adds per-channel grant and stall counters.
module pipe_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  pipe_share_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] grant_cnt_0,
  output logic [31:0] grant_cnt_1,
  output logic [31:0] stall_cnt_0,
  output logic [31:0] stall_cnt_1
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q [2];
  logic [PW-1:0]     rd_ptr_q [2];
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_d [2];
  logic [DATA_W-1:0] din [2];
  logic [1:0]        vld, flush, full, push, elig, pop;
  logic              free, grant, gnt, rr_last_q;
  logic              pipe_valid_q, pipe_tag_q, pipe_flush_q;
  logic [DATA_W-1:0] pipe_data_q;
  logic [1:0]        pipe_flush_mask_q;
  assign vld   = {bus.req_valid_1, bus.req_valid_0};
  assign flush = {bus.req_flush_1, bus.req_flush_0};
  assign din[0] = bus.req_data_0;
  assign din[1] = bus.req_data_1;
  assign free  = !pipe_valid_q || !bus.pipe_stall;
  assign grant = free && (elig != 2'b00);
  assign gnt   = (elig == 2'b11) ? !rr_last_q : elig[1];
  assign pop   = grant ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]  = cnt_q[i] == CW'(FIFO_DEPTH);
      push[i]  = vld[i] && !full[i] && !flush[i];
      elig[i]  = (cnt_q[i] != '0) && !flush[i];
      cnt_d[i] = flush[i] ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= flush[i] ? '0 : wr_ptr_q[i] + PW'(push[i]);
        rd_ptr_q[i] <= flush[i] ? '0 : rd_ptr_q[i] + PW'(pop[i]);
      end
    end
  end
  // Storage needs no reset: count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= din[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q      <= 1'b0;
      pipe_data_q       <= '0;
      pipe_tag_q        <= 1'b0;
      pipe_flush_q      <= 1'b0;
      pipe_flush_mask_q <= 2'b00;
      rr_last_q         <= 1'b1;
    end else begin
      pipe_flush_q      <= |flush;
      pipe_flush_mask_q <= flush;
      if (grant) begin
        pipe_valid_q <= 1'b1;
        pipe_data_q  <= mem_q[gnt][rd_ptr_q[gnt]];
        pipe_tag_q   <= gnt;
        rr_last_q    <= gnt;
      end else if (free || flush[pipe_tag_q]) begin
        pipe_valid_q <= 1'b0;
      end
    end
  end
  assign bus.req_stall_0     = full[0];
  assign bus.req_stall_1     = full[1];
  assign bus.pipe_valid      = pipe_valid_q;
  assign bus.pipe_data       = pipe_data_q;
  assign bus.pipe_tag        = pipe_tag_q;
  assign bus.pipe_flush      = pipe_flush_q;
  assign bus.pipe_flush_mask = pipe_flush_mask_q;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [2];
  logic [31:0] stall_cnt_q [2];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        grant_cnt_q[i] <= grant_cnt_q[i] + 32'(pop[i]);
        stall_cnt_q[i] <= stall_cnt_q[i] + 32'(vld[i] && full[i]);
      end
    end
  end
  assign grant_cnt_0 = grant_cnt_q[0];
  assign grant_cnt_1 = grant_cnt_q[1];
  assign stall_cnt_0 = stall_cnt_q[0];
  assign stall_cnt_1 = stall_cnt_q[1];
`endif
endmodule

// File: tb/tb_pipe_share_arbiter.sv
// tb_pipe_share_arbiter: directed stimulus with a scoreboard monitor on pipeline transfers
module tb_pipe_share_arbiter;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [DW:0] exp_q [$];
  pipe_share_arbiter_if #(.DATA_W(DW)) bus ();
`ifdef ARB_PERF_CNT_EN
  logic [31:0] g0, g1, s0, s1;
  pipe_share_arbiter #(.DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_cnt_0(g0), .grant_cnt_1(g1), .stall_cnt_0(s0), .stall_cnt_1(s1));
`else
  pipe_share_arbiter #(.DATA_W(DW), .FIFO_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", n, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_item(input logic tag, input logic [DW-1:0] d);
    exp_q.push_back({tag, d});
  endtask

  task automatic idle();
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    bus.req_flush_0 = 0; bus.req_flush_1 = 0;
  endtask

  task automatic do_reset();
    idle();
    bus.pipe_stall = 0;
    reset = 1;
    cyc(2);
    reset = 0;
    cyc(1);
  endtask

  // Hold valid/data on channel 0 until the registered stall lets the push through.
  task automatic send0(input logic [DW-1:0] d);
    bit acc;
    int n = 0;
    bus.req_valid_0 = 1;
    bus.req_data_0  = d;
    do begin
      acc = !bus.req_stall_0;
      cyc(1);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send0_timeout", 64'(n), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.pipe_valid && !bus.pipe_stall) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got=%0h tag=%0d exp=none", bus.pipe_data, bus.pipe_tag);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({bus.pipe_tag, bus.pipe_data} === e) pass_cnt++;
        else $display("FAIL sb_item got=%0h exp=%0h", {bus.pipe_tag, bus.pipe_data}, e);
      end
    end
  end

  initial begin
    idle();
    bus.req_data_0 = '0; bus.req_data_1 = '0;
    bus.pipe_stall = 0;
    #2;
    check("rst_valid", 64'(bus.pipe_valid), 0);
    check("rst_data", 64'(bus.pipe_data), 0);
    check("rst_tag", 64'(bus.pipe_tag), 0);
    check("rst_flush", 64'({bus.pipe_flush, bus.pipe_flush_mask}), 0);
    check("rst_stall", 64'({bus.req_stall_1, bus.req_stall_0}), 0);
    do_reset();

    // single channel latency and order
    expect_item(0, 5); expect_item(0, 6); expect_item(0, 7);
    bus.req_valid_0 = 1; bus.req_data_0 = 5;
    cyc(1);
    check("lat_not_yet", 64'(bus.pipe_valid), 0);
    bus.req_data_0 = 6;
    cyc(1);
    check("lat_first", 64'({bus.pipe_valid, bus.pipe_data}), {32'd1, 32'd5});
    bus.req_data_0 = 7;
    cyc(1);
    check("lat_second", 64'(bus.pipe_data), 6);
    idle();
    cyc(4);
    check("single_drained", 64'(bus.pipe_valid), 0);

    // round robin, channel 0 wins first after reset
    do_reset();
    expect_item(0, 'h10); expect_item(1, 'h20); expect_item(0, 'h11); expect_item(1, 'h21);
    bus.req_valid_0 = 1; bus.req_data_0 = 'h10;
    bus.req_valid_1 = 1; bus.req_data_1 = 'h20;
    cyc(1);
    bus.req_data_0 = 'h11; bus.req_data_1 = 'h21;
    cyc(1);
    idle();
    cyc(6);

    // backpressure
    do_reset();
    expect_item(0, 'h30); expect_item(0, 'h31); expect_item(0, 'h32); expect_item(0, 'h33);
    bus.pipe_stall = 1;
    send0('h30);
    send0('h31);
    check("bp_not_full", 64'(bus.req_stall_0), 0);
    send0('h32);
    check("bp_full", 64'(bus.req_stall_0), 1);
    check("bp_hold", 64'({bus.pipe_valid, bus.pipe_data}), {32'd1, 32'h30});
    bus.req_data_0 = 'h33;
    cyc(2);
    check("bp_still_full", 64'(bus.req_stall_0), 1);
    check("bp_hold2", 64'(bus.pipe_data), 'h30);
    bus.pipe_stall = 0;
    cyc(1);
    check("bp_stall_drop", 64'(bus.req_stall_0), 0);
    cyc(1);
    idle();
    cyc(6);

    // flush under stall
    do_reset();
    bus.pipe_stall = 1;
    bus.req_valid_1 = 1; bus.req_data_1 = 'h40;
    cyc(1);
    bus.req_data_1 = 'h41;
    cyc(1);
    bus.req_data_1 = 'h42;
    cyc(1);
    bus.req_valid_1 = 0;
    check("fl_pre", 64'({bus.pipe_valid, bus.pipe_tag, bus.req_stall_1}), 64'b111);
    bus.req_flush_1 = 1;
    cyc(1);
    bus.req_flush_1 = 0;
    check("fl_valid", 64'(bus.pipe_valid), 0);
    check("fl_stall1", 64'(bus.req_stall_1), 0);
    check("fl_pulse", 64'({bus.pipe_flush, bus.pipe_flush_mask}), 64'b110);
    cyc(1);
    check("fl_one_cycle", 64'({bus.pipe_flush, bus.pipe_flush_mask}), 0);
    bus.pipe_stall = 0;
    cyc(4);
    check("fl_fifo_empty", 64'(bus.pipe_valid), 0);

    // flush/push collision drops the push
    bus.req_valid_0 = 1; bus.req_data_0 = 'hAA; bus.req_flush_0 = 1;
    cyc(1);
    idle();
    check("col_mask", 64'({bus.pipe_flush, bus.pipe_flush_mask}), 64'b101);
    cyc(4);
    expect_item(0, 'hAB);
    bus.req_valid_0 = 1; bus.req_data_0 = 'hAB;
    cyc(1);
    idle();
    cyc(4);

    // async reset mid-burst
    bus.pipe_stall = 1;
    bus.req_valid_0 = 1; bus.req_data_0 = 'h50;
    cyc(1);
    bus.req_data_0 = 'h51;
    cyc(1);
    bus.req_data_0 = 'h52;
    cyc(2);
    check("ar_pre", 64'({bus.pipe_valid, bus.req_stall_0}), 64'b11);
    #3 reset = 1;
    #1;
    check("ar_valid", 64'(bus.pipe_valid), 0);
    check("ar_stall", 64'({bus.req_stall_1, bus.req_stall_0}), 0);
    idle();
    bus.pipe_stall = 0;
    cyc(1);
    reset = 0;
    cyc(1);
    expect_item(0, 'h60); expect_item(1, 'h70);
    bus.req_valid_0 = 1; bus.req_data_0 = 'h60;
    bus.req_valid_1 = 1; bus.req_data_1 = 'h70;
    cyc(1);
    idle();
    cyc(6);

    check("sb_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
